// File: rtl/button_pkg.sv
// Shared types for the pushbutton debouncer: FSM state encoding (IDLE is the reset value).
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } debounce_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff <= '0;
    else      ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: synchronizer, four-state debounce FSM, registered level/press/release pulses.
// Optional long-press pulse is built only when BUTTON_LONG_PRESS_EN is defined.
module button_debouncer
  import button_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 240000,
  parameter int LONG_PRESS_CYCLES = 12000000
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic button_raw,
  output logic button_level,
  output logic button_press,
  output logic button_release,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            s;
  debounce_state_t state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            press_evt, release_evt;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // The counter only advances below DEB_LAST, so it can never wrap.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_d   = PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt == DEB_LAST) begin
          state_d     = IDLE;
          release_evt = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulses are gated by ena at the edge they would fire; masked events are simply lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      button_level   <= 1'b0;
      button_press   <= 1'b0;
      button_release <= 1'b0;
    end else begin
      button_level   <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      button_press   <= ena & press_evt;
      button_release <= ena & release_evt;
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          hold_fired;

  // Hold count restarts on each accepted press; hold_fired limits long_press to one pulse per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt   <= '0;
      hold_fired <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_evt) begin
        hold_cnt   <= '0;
        hold_fired <= 1'b0;
      end else if ((state == PRESSED) || (state == RELEASE_WAIT)) begin
        if (hold_cnt != HOLD_LAST) begin
          hold_cnt <= hold_cnt + HW'(1);
        end else if (!hold_fired) begin
          hold_fired <= 1'b1;
          long_press <= ena;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic ena;
  logic button_raw;
  logic button_level;
  logic button_press;
  logic button_release;
  logic long_press;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .SYNC_STAGES       (2),
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .button_raw     (button_raw),
    .button_level   (button_level),
    .button_press   (button_press),
    .button_release (button_release),
    .long_press     (long_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1ns past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst        = 1'b0;
    ena        = 1'b1;
    button_raw = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({button_level, button_press, button_release, long_press} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: level/press/release/long=%b%b%b%b expected 0000",
               button_level, button_press, button_release, long_press);
    end
  endtask

  task automatic test_clean_press();
    button_raw = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      logic exp_p, exp_l;
      tick();
      exp_p = (e == 7);
      exp_l = (e >= 7);
      checks++;
      if (button_press !== exp_p || button_level !== exp_l || button_release !== 1'b0) begin
        errors++;
        $display("FAIL clean_press edge %0d: press=%b level=%b release=%b expected press=%b level=%b release=0",
                 e, button_press, button_level, button_release, exp_p, exp_l);
      end
    end
  endtask

  task automatic test_release();
    button_raw = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      logic exp_r, exp_l;
      tick();
      exp_r = (e == 7);
      exp_l = (e < 7);
      checks++;
      if (button_release !== exp_r || button_level !== exp_l || button_press !== 1'b0) begin
        errors++;
        $display("FAIL release edge %0d: release=%b level=%b press=%b expected release=%b level=%b press=0",
                 e, button_release, button_level, button_press, exp_r, exp_l);
      end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pattern;
    pattern = 16'b0000_0000_0011_0111;  // LSB first: high 3, low 1, high 2, then low
    for (int e = 0; e < 16; e++) begin
      button_raw = pattern[e];
      tick();
      checks++;
      if (button_press !== 1'b0 || button_level !== 1'b0) begin
        errors++;
        $display("FAIL bounce edge %0d: press=%b level=%b expected press=0 level=0",
                 e + 1, button_press, button_level);
      end
    end
  endtask

  task automatic test_release_bounce();
    button_raw = 1'b1;
    repeat (9) tick();
    checks++;
    if (button_level !== 1'b1) begin
      errors++;
      $display("FAIL release_bounce_setup: level=%b expected 1", button_level);
    end
    for (int e = 0; e < 12; e++) begin
      button_raw = (e >= 3) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if (button_release !== 1'b0 || button_level !== 1'b1) begin
        errors++;
        $display("FAIL release_bounce edge %0d: release=%b level=%b expected release=0 level=1",
                 e + 1, button_release, button_level);
      end
    end
    button_raw = 1'b0;
    repeat (10) tick();
    checks++;
    if (button_level !== 1'b0) begin
      errors++;
      $display("FAIL release_bounce_exit: level=%b expected 0", button_level);
    end
  endtask

  task automatic test_long_press();
    int press_edge, lp_edge, lp_count;
    int exp_count, exp_edge;
`ifdef BUTTON_LONG_PRESS_EN
    exp_count = 1;
    exp_edge  = 17;
`else
    exp_count = 0;
    exp_edge  = -1;
`endif
    press_edge = -1;
    lp_edge    = -1;
    lp_count   = 0;
    button_raw = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (button_press === 1'b1) press_edge = e;
      if (long_press === 1'b1) begin
        lp_count++;
        lp_edge = e;
      end
      if (e == 40) button_raw = 1'b0;
    end
    checks++;
    if (press_edge !== 7) begin
      errors++;
      $display("FAIL long_press_press_edge: got %0d expected 7", press_edge);
    end
    checks++;
    if (lp_count !== exp_count) begin
      errors++;
      $display("FAIL long_press_count: got %0d expected %0d", lp_count, exp_count);
    end
    checks++;
    if (lp_edge !== exp_edge) begin
      errors++;
      $display("FAIL long_press_edge: got %0d expected %0d", lp_edge, exp_edge);
    end
    checks++;
    if (button_level !== 1'b0) begin
      errors++;
      $display("FAIL long_press_exit: level=%b expected 0", button_level);
    end
  endtask

  task automatic test_mask();
    ena        = 1'b0;
    button_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (button_press !== 1'b0 || button_level !== (e >= 7)) begin
        errors++;
        $display("FAIL mask edge %0d: press=%b level=%b expected press=0 level=%b",
                 e, button_press, button_level, (e >= 7));
      end
    end
    ena = 1'b1;
    for (int e = 8; e <= 12; e++) begin
      tick();
      checks++;
      if (button_press !== 1'b0 || button_level !== 1'b1) begin
        errors++;
        $display("FAIL mask_no_replay edge %0d: press=%b level=%b expected press=0 level=1",
                 e, button_press, button_level);
      end
    end
    button_raw = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    button_raw = 1'b1;
    repeat (4) tick();
    @(posedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({button_level, button_press, button_release, long_press} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_outputs: level/press/release/long=%b%b%b%b expected 0000",
               button_level, button_press, button_release, long_press);
    end
    repeat (2) tick();
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (button_press !== (e == 7) || button_level !== (e >= 7)) begin
        errors++;
        $display("FAIL reset_mid_repress edge %0d: press=%b level=%b expected press=%b level=%b",
                 e, button_press, button_level, (e == 7), (e >= 7));
      end
    end
  endtask

  task automatic test_reset_async();
    // DUT is pressed here; reset is asserted between edges and must act at once.
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (button_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: level=%b expected 0", button_level);
    end
    button_raw = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();
    checks++;
    if ({button_level, button_press, button_release} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async_idle: level/press/release=%b%b%b expected 000",
               button_level, button_press, button_release);
    end
  endtask

  initial begin
    rst        = 1'b0;
    ena        = 1'b1;
    button_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release_bounce();
    test_long_press();
    test_mask();
    test_reset_mid();
    test_reset_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 240000, stable-input cycles required to accept a level change (minimum 2).
REQ-003 SHALL have parameter LONG_PRESS_CYCLES, default 12000000, held-press cycles before long_press (minimum 2).
REQ-004 SHALL have port clk, input, 1, the single system clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ena, input, 1, pulse-output enable.
REQ-007 SHALL have port button_raw, input, 1, asynchronous bouncing pushbutton, 1 = pressed.
REQ-008 SHALL have port button_level, output, 1, debounced pressed level.
REQ-009 SHALL have port button_press, output, 1, one-cycle pulse on an accepted press; this is the button_press input of the downstream LED state stage.
REQ-010 SHALL have port button_release, output, 1, one-cycle pulse on an accepted release.
REQ-011 SHALL have port long_press, output, 1, one-cycle pulse once per long hold.

Function
REQ-012 button_raw SHALL pass through SYNC_STAGES flops; s denotes the last flop output.
REQ-013 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE: s=1 -> PRESS_WAIT with debounce counter cleared to 0; else stay.
REQ-015 PRESS_WAIT: s=0 -> IDLE with no pulse; s=1 and count==DEBOUNCE_CYCLES-1 -> PRESSED; else count+1.
REQ-016 PRESSED: s=0 -> RELEASE_WAIT with counter cleared; else stay.
REQ-017 RELEASE_WAIT: s=1 -> PRESSED with no pulse; s=0 and count==DEBOUNCE_CYCLES-1 -> IDLE; else count+1.
REQ-018 All outputs SHALL be registered and change on the same edge as the FSM transition that causes them.
REQ-019 button_level SHALL be 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-020 button_press SHALL be 1 for one cycle on the PRESS_WAIT->PRESSED edge; button_release SHALL be 1 for one cycle on the RELEASE_WAIT->IDLE edge.
REQ-021 Latency: with button_raw held high from before edge 1, button_press SHALL assert at edge SYNC_STAGES+DEBOUNCE_CYCLES+1; release latency SHALL be identical.
REQ-022 ena=0 SHALL mask all three pulse outputs to 0 while the FSM and button_level keep tracking; a masked pulse SHALL NOT be replayed when ena returns to 1.
REQ-023 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap.

Reset
REQ-024 rst low SHALL immediately force the synchronizer flops to 0, the FSM to IDLE, all counters to 0, and all outputs to 0, regardless of the clock.
REQ-025 Reset mid-debounce SHALL discard progress; after reset release with button_raw still high, a full debounce and a new button_press SHALL occur.

Configuration
REQ-026 Macro BUTTON_LONG_PRESS_EN SHALL control long-press support.
REQ-027 Defined: a hold counter SHALL clear on entry to PRESSED from PRESS_WAIT and increment every cycle in PRESSED or RELEASE_WAIT, saturating at LONG_PRESS_CYCLES-1.
REQ-028 Defined: long_press SHALL pulse once, at edge button_press+LONG_PRESS_CYCLES, with no repeat until the next accepted press, masked by ena.
REQ-029 Not defined: the hold counter SHALL be absent, long_press SHALL be tied to 0, and LONG_PRESS_CYCLES SHALL be ignored.

Structure
REQ-030 Package button_pkg SHALL hold the debounce_state_t enum, with IDLE as the reset encoding.
REQ-031 Sub-module sync_chain, parameterized by SYNC_STAGES with asynchronous active-low reset, SHALL implement the synchronizer.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ena=1 unless stated)
REQ-032 Clean press: button_raw 0->1 and held -> button_press high for exactly one cycle at edge 7; button_level 1 from edge 7.
REQ-033 Bounce: button_raw high 3 cycles, low 1, high 2, then low -> no pulses; button_level stays 0.
REQ-034 Release: after an accepted press, button_raw ->0 and held -> button_release single pulse 7 edges later; release-side bounce shorter than 4 cycles -> no pulse and button_level stays 1.
REQ-035 Long press (macro defined): hold 40 cycles -> exactly one long_press, 10 edges after button_press; macro undefined -> long_press always 0.
REQ-036 Reset mid-PRESS_WAIT: rst low at edge 5 -> all outputs 0 immediately; rst high with button_raw still high -> button_press 7 edges after the first clock edge following reset release.
REQ-037 Masking: ena=0 across the press edge -> button_press stays 0 and button_level becomes 1; ena->1 while held -> no late pulse.
